reg_file: RTL and testbench

Register file with 16 entries of 8 bits, two combinational read ports and one clocked write port. It holds operand values for the datapath: two source operands are read in the same cycle and one result is written back on the clock edge. All storage is cleared by a synchronous reset.

---
 rtl/reg_file.sv | 25 ++
 tb/tb_reg_file.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x DATA_WIDTH registers; ports clk, reset (sync, high, clears all), WA/data_in/write_enable (clocked write), RA1/RA2 -> data_out1/data_out2 (combinational reads, no bypass)
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] RA2,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (write_enable)
      regs[WA] <= data_in;
  assign data_out1 = regs[RA1];
  assign data_out2 = regs[RA2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file
module tb_reg_file;
  logic [3:0] ra1, ra2, wa;
  logic [7:0] data_in, data_out1, data_out2;
  logic clk = 0, reset = 0, write_enable = 0;
  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] e;
  int checks = 0, errors = 0;

  reg_file dut (
    .RA1(ra1), .RA2(ra2), .WA(wa), .data_in(data_in), .clk(clk), .reset(reset),
    .write_enable(write_enable), .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  task automatic step();
    if (reset)
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
    else if (write_enable)
      model[wa] = data_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; write_enable = 1; wa = 4'd3; data_in = 8'hAA;
    step();
    reset = 0; write_enable = 0;
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i);
      #1;
      exp_q.push_back(model[i]);
      exp_q.push_back(model[15 - i]);
      e = exp_q.pop_front(); checks++;
      if (data_out1 !== e) begin errors++; $display("FAIL reset_out1 addr=%0d got=%h exp=%h", i, data_out1, e); end
      e = exp_q.pop_front(); checks++;
      if (data_out2 !== e) begin errors++; $display("FAIL reset_out2 addr=%0d got=%h exp=%h", 15 - i, data_out2, e); end
    end
  endtask

  task automatic test_basic_writes();
    logic [3:0] was [3] = '{4'd0, 4'd1, 4'd5};
    logic [7:0] ds [3] = '{8'd5, 8'd7, 8'd13};
    logic [7:0] e1 [3] = '{8'd0, 8'd7, 8'd7};
    ra1 = 4'd1; ra2 = 4'd2; write_enable = 1;
    for (int k = 0; k < 3; k++) begin
      wa = was[k]; data_in = ds[k];
      step();
      exp_q.push_back(e1[k]);
      exp_q.push_back(8'd0);
      e = exp_q.pop_front(); checks++;
      if (data_out1 !== e || data_out1 !== model[1]) begin errors++; $display("FAIL basic_out1 edge=%0d got=%h exp=%h", k, data_out1, e); end
      e = exp_q.pop_front(); checks++;
      if (data_out2 !== e) begin errors++; $display("FAIL basic_out2 edge=%0d got=%h exp=%h", k, data_out2, e); end
    end
    write_enable = 0;
    ra2 = 4'd5;
    #1;
    exp_q.push_back(8'd13);
    e = exp_q.pop_front(); checks++;
    if (data_out2 !== e) begin errors++; $display("FAIL basic_comb_read got=%h exp=%h", data_out2, e); end
    ra1 = 4'd0;
    #1;
    exp_q.push_back(8'd5);
    e = exp_q.pop_front(); checks++;
    if (data_out1 !== e) begin errors++; $display("FAIL basic_r0 got=%h exp=%h", data_out1, e); end
  endtask

  task automatic test_write_disable();
    write_enable = 0; wa = 4'd5; data_in = 8'hFF; ra1 = 4'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_q.push_back(8'd13);
      e = exp_q.pop_front(); checks++;
      if (data_out1 !== e) begin errors++; $display("FAIL write_disable edge=%0d got=%h exp=%h", k, data_out1, e); end
    end
  endtask

  task automatic test_read_during_write();
    write_enable = 1; wa = 4'd4; data_in = 8'd2;
    step();
    ra1 = 4'd4; data_in = 8'd9;
    #1;
    exp_q.push_back(8'd2);
    e = exp_q.pop_front(); checks++;
    if (data_out1 !== e) begin errors++; $display("FAIL rdw_before got=%h exp=%h", data_out1, e); end
    step();
    write_enable = 0;
    exp_q.push_back(8'd9);
    e = exp_q.pop_front(); checks++;
    if (data_out1 !== e) begin errors++; $display("FAIL rdw_after got=%h exp=%h", data_out1, e); end
  endtask

  task automatic test_dual_read();
    ra1 = 4'd5; ra2 = 4'd5;
    #1;
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd13);
    e = exp_q.pop_front(); checks++;
    if (data_out1 !== e) begin errors++; $display("FAIL dual_out1 got=%h exp=%h", data_out1, e); end
    e = exp_q.pop_front(); checks++;
    if (data_out2 !== e) begin errors++; $display("FAIL dual_out2 got=%h exp=%h", data_out2, e); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] as [3] = '{4'd0, 4'd1, 4'd5};
    @(negedge clk);
    reset = 1; ra1 = 4'd5;
    #1;
    exp_q.push_back(8'd13);
    e = exp_q.pop_front(); checks++;
    if (data_out1 !== e) begin errors++; $display("FAIL reset_is_sync got=%h exp=%h", data_out1, e); end
    step();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      ra1 = as[k]; ra2 = as[2 - k];
      #1;
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      e = exp_q.pop_front(); checks++;
      if (data_out1 !== e) begin errors++; $display("FAIL mid_reset_out1 addr=%0d got=%h exp=%h", as[k], data_out1, e); end
      e = exp_q.pop_front(); checks++;
      if (data_out2 !== e) begin errors++; $display("FAIL mid_reset_out2 addr=%0d got=%h exp=%h", as[2 - k], data_out2, e); end
    end
  endtask

  initial begin
    ra1 = 0; ra2 = 0; wa = 0; data_in = 0;
    @(negedge clk);
    test_reset();
    test_basic_writes();
    test_write_disable();
    test_read_during_write();
    test_dual_read();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
